// File: rtl/r_id_reorder_unit_if.sv
// rtl/r_id_reorder_unit_if.sv - R channel bundle used on both sides of the reorder unit
//
// Purpose: groups the AXI R-channel fields of one stream so the reorder unit
// can take its input and output as single ports.
// Parameters: ID_WIDTH (RID width), DATA_WIDTH (RDATA width).
// Signals: valid, ready, id, data, resp[1:0], last.
// Modports: sender (drives payload, samples ready), receiver (the reverse).

interface r_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;

    modport sender   (output valid, id, data, resp, last, input  ready);
    modport receiver (input  valid, id, data, resp, last, output ready);
endinterface

// File: rtl/r_id_reorder_unit.sv
// rtl/r_id_reorder_unit.sv - stores out-of-order R bursts and replays them in AR issue order
//
// Purpose: whole R bursts arriving in any order are captured into NUM_SLOTS
// burst slots and re-emitted on out_r in the order recorded on the alloc port.
// Optional feature macro: R_REORDER_IDCHK_EN (adds the sticky unexpected-ID flag).
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   alloc_valid/ready   push alloc_id into the issue-order queue
//   alloc_id            ID of the issued AR
//   in_r                R bursts from the response buffer (receiver)
//   out_r               R bursts toward the master, in issue order (sender)
//   err_unexpected_id   sticky flag, only with R_REORDER_IDCHK_EN

module r_id_reorder_unit #(
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_BEATS   = 16,
    parameter int NUM_SLOTS   = 4,
    parameter int ORDER_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic [ID_WIDTH-1:0] alloc_id,
    r_if.receiver               in_r,
    r_if.sender                 out_r
`ifdef R_REORDER_IDCHK_EN
    ,
    output logic                err_unexpected_id
`endif
);

    localparam int NB_W  = $clog2(MAX_BEATS + 1);
    localparam int BA_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int SL_W  = $clog2(NUM_SLOTS);
    localparam int FC_W  = $clog2(NUM_SLOTS + 1);
    localparam int OQ_AW = $clog2(ORDER_DEPTH);
    localparam int CNT_W = OQ_AW + 1;

    typedef enum logic {ST_IDLE, ST_SEND} out_state_t;

    // ---------------- issue-order queue ----------------
    logic [ID_WIDTH-1:0] oq_mem [ORDER_DEPTH];
    logic [OQ_AW-1:0]    oq_wr, oq_rd;
    logic [CNT_W-1:0]    oq_cnt;
    logic                oq_full, oq_empty, oq_push, oq_pop;
    logic [ID_WIDTH-1:0] head_id;

    assign oq_full     = (oq_cnt == CNT_W'(ORDER_DEPTH));
    assign oq_empty    = (oq_cnt == '0);
    assign head_id     = oq_mem[oq_rd];
    assign alloc_ready = ~oq_full;
    assign oq_push     = alloc_valid & ~oq_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oq_wr  <= '0;
            oq_rd  <= '0;
            oq_cnt <= '0;
        end else begin
            if (oq_push) oq_wr <= oq_wr + OQ_AW'(1);
            if (oq_pop)  oq_rd <= oq_rd + OQ_AW'(1);
            case ({oq_push, oq_pop})
                2'b10:   oq_cnt <= oq_cnt + CNT_W'(1);
                2'b01:   oq_cnt <= oq_cnt - CNT_W'(1);
                default: oq_cnt <= oq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (oq_push) oq_mem[oq_wr] <= alloc_id;
    end

    // ---------------- slot state ----------------
    logic                  slot_busy     [NUM_SLOTS];
    logic                  slot_complete [NUM_SLOTS];
    logic [ID_WIDTH-1:0]   slot_id       [NUM_SLOTS];
    logic [NB_W-1:0]       slot_nbeats   [NUM_SLOTS];
    logic [7:0]            slot_stamp    [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] slot_data     [NUM_SLOTS][MAX_BEATS];
    logic [1:0]            slot_resp     [NUM_SLOTS][MAX_BEATS];

    logic            in_mid;
    logic [SL_W-1:0] in_slot;
    logic [7:0]      seq_cnt;

    // Allocation view is taken from registered state only, so a slot freed by
    // the output side this cycle is not reused until the next one.
    logic [FC_W-1:0] free_cnt;
    logic [SL_W-1:0] free_idx;
    logic            free_found;
    logic            head_held;

    always_comb begin
        free_cnt   = '0;
        free_idx   = '0;
        free_found = 1'b0;
        head_held  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_busy[i]) begin
                free_cnt = free_cnt + FC_W'(1);
                if (!free_found) begin
                    free_idx   = SL_W'(i);
                    free_found = 1'b1;
                end
            end
            if (slot_busy[i] && slot_id[i] == head_id) head_held = 1'b1;
        end
    end

    // The last free slot is kept for the head ID; otherwise non-head bursts
    // could fill every slot and the head burst could never be accepted.
    logic in_ready, in_fire, in_first;
    logic [SL_W-1:0] cur_slot;
    logic [BA_W-1:0] wr_beat;
    logic            wr_ok;

    always_comb begin
        if (in_mid)
            in_ready = 1'b1;
        else
            in_ready = (free_cnt >= FC_W'(2)) ||
                       ((free_cnt == FC_W'(1)) && !oq_empty &&
                        (in_r.id == head_id) && !head_held);
    end

    assign in_r.ready = in_ready;
    assign in_fire    = in_r.valid & in_ready;
    assign in_first   = in_fire & ~in_mid;
    assign cur_slot   = in_mid ? in_slot : free_idx;
    assign wr_beat    = in_mid ? BA_W'(slot_nbeats[in_slot]) : '0;
    assign wr_ok      = !in_mid || (slot_nbeats[in_slot] < NB_W'(MAX_BEATS));

    // ---------------- output side ----------------
    out_state_t      state, state_nx;
    logic [SL_W-1:0] sel_slot;
    logic [BA_W-1:0] idx;
    logic            out_done;
    logic            pick_found;
    logic [SL_W-1:0] pick_idx;
    logic [7:0]      pick_stamp;
    logic [7:0]      stamp_diff;

    assign oq_pop = out_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_mid  <= 1'b0;
            in_slot <= '0;
            seq_cnt <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_busy[i]     <= 1'b0;
                slot_complete[i] <= 1'b0;
                slot_id[i]       <= '0;
                slot_nbeats[i]   <= '0;
                slot_stamp[i]    <= '0;
            end
        end else begin
            if (out_done) begin
                slot_busy[sel_slot]     <= 1'b0;
                slot_complete[sel_slot] <= 1'b0;
            end
            if (in_fire) begin
                in_mid <= ~in_r.last;
                if (in_first) begin
                    in_slot               <= free_idx;
                    slot_busy[free_idx]   <= 1'b1;
                    slot_id[free_idx]     <= in_r.id;
                    slot_stamp[free_idx]  <= seq_cnt;
                    slot_nbeats[free_idx] <= NB_W'(1);
                    seq_cnt               <= seq_cnt + 8'd1;
                end else if (slot_nbeats[in_slot] < NB_W'(MAX_BEATS)) begin
                    slot_nbeats[in_slot] <= slot_nbeats[in_slot] + NB_W'(1);
                end
                if (in_r.last) slot_complete[cur_slot] <= 1'b1;
            end
        end
    end

    // Payload carries no reset: it is only ever read from a complete slot.
    always_ff @(posedge clk) begin
        if (in_fire && wr_ok) begin
            slot_data[cur_slot][wr_beat] <= in_r.data;
            slot_resp[cur_slot][wr_beat] <= in_r.resp;
        end
    end

    // Oldest complete slot matching the head ID; stamps compared modulo 256
    // (a negative difference means "older").
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_stamp = '0;
        stamp_diff = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!oq_empty && slot_complete[i] && slot_id[i] == head_id) begin
                stamp_diff = slot_stamp[i] - pick_stamp;
                if (!pick_found || stamp_diff[7]) begin
                    pick_found = 1'b1;
                    pick_idx   = SL_W'(i);
                    pick_stamp = slot_stamp[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    logic                  o_valid, o_last;
    logic [ID_WIDTH-1:0]   o_id;
    logic [DATA_WIDTH-1:0] o_data;
    logic [1:0]            o_resp;

    always_comb begin
        state_nx = state;
        o_valid  = 1'b0;
        o_id     = '0;
        o_data   = '0;
        o_resp   = '0;
        o_last   = 1'b0;
        out_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) state_nx = ST_SEND;
            end
            ST_SEND: begin
                o_valid = 1'b1;
                o_id    = slot_id[sel_slot];
                o_data  = slot_data[sel_slot][idx];
                o_resp  = slot_resp[sel_slot][idx];
                o_last  = (NB_W'(idx) == slot_nbeats[sel_slot] - NB_W'(1));
                if (out_r.ready && o_last) begin
                    out_done = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign out_r.valid = o_valid;
    assign out_r.id    = o_id;
    assign out_r.data  = o_data;
    assign out_r.resp  = o_resp;
    assign out_r.last  = o_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_slot <= '0;
            idx      <= '0;
        end else if (state == ST_IDLE) begin
            idx <= '0;
            if (pick_found) sel_slot <= pick_idx;
        end else if (out_r.ready) begin
            idx <= idx + BA_W'(1);
        end
    end

`ifdef R_REORDER_IDCHK_EN
    // An accepted first beat whose ID is in no live queue entry is flagged.
    logic             id_known;
    logic [OQ_AW-1:0] oq_off;

    always_comb begin
        id_known = 1'b0;
        oq_off   = '0;
        for (int i = 0; i < ORDER_DEPTH; i++) begin
            oq_off = OQ_AW'(i) - oq_rd;
            if (({1'b0, oq_off} < oq_cnt) && (oq_mem[i] == in_r.id)) id_known = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        err_unexpected_id <= 1'b0;
        else if (in_first && !id_known) err_unexpected_id <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_r_id_reorder_unit.sv
// tb/tb_r_id_reorder_unit.sv - scoreboard bench for r_id_reorder_unit

module tb_r_id_reorder_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [3:0] alloc_id;
`ifdef R_REORDER_IDCHK_EN
    logic       err_unexpected_id;
`endif

    r_if #(.ID_WIDTH(4), .DATA_WIDTH(64)) in_if ();
    r_if #(.ID_WIDTH(4), .DATA_WIDTH(64)) out_if ();

    r_id_reorder_unit #(
        .ID_WIDTH(4), .DATA_WIDTH(64), .MAX_BEATS(16), .NUM_SLOTS(4), .ORDER_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .alloc_id(alloc_id),
        .in_r(in_if),
        .out_r(out_if)
`ifdef R_REORDER_IDCHK_EN
        ,
        .err_unexpected_id(err_unexpected_id)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [70:0] exp_q[$];
    bit toggle_mode = 1'b0;
    bit out_ready_fixed = 1'b1;

    function automatic logic [70:0] beat(input logic [3:0] id, input logic [63:0] data,
                                         input logic [1:0] resp, input logic last);
        return {last, resp, id, data};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_alloc(input logic [3:0] id);
        alloc_valid = 1'b1;
        alloc_id    = id;
        @(posedge clk); #1;
        alloc_valid = 1'b0;
    endtask

    task automatic expect_burst(input logic [3:0] id, input int n, input logic [63:0] base);
        for (int b = 0; b < n; b++)
            exp_q.push_back(beat(id, base + 64'(b), 2'(b), (b == n - 1)));
    endtask

    task automatic send_burst(input logic [3:0] id, input int n, input logic [63:0] base);
        bit acc;
        int budget;
        for (int b = 0; b < n; b++) begin
            in_if.valid = 1'b1;
            in_if.id    = id;
            in_if.data  = base + 64'(b);
            in_if.resp  = 2'(b);
            in_if.last  = (b == n - 1);
            acc    = 1'b0;
            budget = 0;
            while (!acc && budget < 200) begin
                @(negedge clk);
                acc = in_if.ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL in_accept_timeout: id %0d beat %0d never accepted, required acceptance", id, b);
            end
        end
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d beats still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // out_r.ready driver
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (toggle_mode) out_if.ready = ~out_if.ready;
            else             out_if.ready = out_ready_fixed;
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks hold stability.
    initial begin
        logic [70:0] cur, held, e;
        bit held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                cur = beat(out_if.id, out_if.data, out_if.resp, out_if.last);
                if (held_v) chk("out_hold", {out_if.valid, cur}, {1'b1, held});
                if (out_if.valid && out_if.ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected_beat: got %h required no beat", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", {1'b1, cur}, {1'b1, e});
                    end
                end
                held_v = out_if.valid && !out_if.ready;
                held   = cur;
            end
        end
    end

    initial begin
        bit seen;
        int k;
        rst = 1'b1;
        alloc_valid = 1'b0;
        alloc_id = '0;
        in_if.valid = 1'b0;
        in_if.id = '0;
        in_if.data = '0;
        in_if.resp = '0;
        in_if.last = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 72'(out_if.valid), 72'd0);
        chk("rst_out_id",    72'(out_if.id),    72'd0);
        chk("rst_out_data",  72'(out_if.data),  72'd0);
        chk("rst_out_resp",  72'(out_if.resp),  72'd0);
        chk("rst_out_last",  72'(out_if.last),  72'd0);
        chk("rst_alloc_ready", 72'(alloc_ready), 72'd1);
        chk("rst_in_ready",  72'(in_if.ready),  72'd1);
`ifdef R_REORDER_IDCHK_EN
        chk("rst_err", 72'(err_unexpected_id), 72'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // out-of-order arrival: id2 before id1
        do_alloc(4'd1);
        do_alloc(4'd2);
        expect_burst(4'd1, 2, 64'h10);
        expect_burst(4'd2, 4, 64'h20);
        send_burst(4'd2, 4, 64'h20);
        send_burst(4'd1, 2, 64'h10);
        wait_drain("drain_ooo");

        // single-beat latency
        do_alloc(4'd4);
        expect_burst(4'd4, 1, 64'h40);
        send_burst(4'd4, 1, 64'h40);
        @(negedge clk);
        chk("lat_t1_valid", 72'(out_if.valid), 72'd0);
        @(negedge clk);
        chk("lat_t2_valid", 72'(out_if.valid), 72'd1);
        wait_drain("drain_latency");
        seen = 1'b0;
        for (k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_if.valid) seen = 1'b1;
        end
        chk("lat_queue_empty_idle", 72'(seen), 72'd0);
        @(posedge clk); #1;

        // same ID twice: stamps decide, head 8 lets both 5s be stored first
        do_alloc(4'd8);
        do_alloc(4'd5);
        do_alloc(4'd5);
        do_alloc(4'd7);
        expect_burst(4'd8, 1, 64'h80);
        expect_burst(4'd5, 2, 64'h50);
        expect_burst(4'd5, 3, 64'h58);
        expect_burst(4'd7, 1, 64'h70);
        send_burst(4'd5, 2, 64'h50);
        send_burst(4'd7, 1, 64'h70);
        send_burst(4'd5, 3, 64'h58);
        send_burst(4'd8, 1, 64'h80);
        wait_drain("drain_stamp");

        // last free slot reserved for head id 3
        do_alloc(4'd3);
        do_alloc(4'd1);
        do_alloc(4'd2);
        do_alloc(4'd6);
        expect_burst(4'd3, 2, 64'h30);
        expect_burst(4'd1, 1, 64'h61);
        expect_burst(4'd2, 1, 64'h62);
        expect_burst(4'd6, 1, 64'h66);
        send_burst(4'd1, 1, 64'h61);
        send_burst(4'd2, 1, 64'h62);
        send_burst(4'd6, 1, 64'h66);
        in_if.valid = 1'b1;
        in_if.id    = 4'd1;
        in_if.last  = 1'b1;
        #1;
        chk("resv_nonhead_ready", 72'(in_if.ready), 72'd0);
        in_if.id = 4'd3;
        #1;
        chk("resv_head_ready", 72'(in_if.ready), 72'd1);
        send_burst(4'd3, 2, 64'h30);
        wait_drain("drain_reserve");

        // ready toggling during an 8-beat burst
        do_alloc(4'd10);
        expect_burst(4'd10, 8, 64'hA0);
        toggle_mode = 1'b1;
        send_burst(4'd10, 8, 64'hA0);
        wait_drain("drain_toggle");
        toggle_mode = 1'b0;
        out_ready_fixed = 1'b1;
        @(posedge clk); #1;

        // reset mid-SEND
        out_ready_fixed = 1'b0;
        do_alloc(4'd11);
        @(posedge clk); #1;
        send_burst(4'd11, 4, 64'hB0);
        seen = 1'b0;
        for (k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_if.valid) seen = 1'b1;
        end
        chk("midsend_valid_seen", 72'(seen), 72'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midsend_rst_valid", 72'(out_if.valid), 72'd0);
        chk("midsend_rst_data",  72'(out_if.data),  72'd0);
        out_ready_fixed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_if.valid) seen = 1'b1;
        end
        chk("post_rst_no_output", 72'(seen), 72'd0);
        chk("post_rst_in_ready", 72'(in_if.ready), 72'd1);
        @(posedge clk); #1;

`ifdef R_REORDER_IDCHK_EN
        // never-allocated id 9
        chk("idchk_before", 72'(err_unexpected_id), 72'd0);
        send_burst(4'd9, 1, 64'h90);
        chk("idchk_set", 72'(err_unexpected_id), 72'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("idchk_sticky", 72'(err_unexpected_id), 72'd1);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/r_id_reorder_unit.md
# r_id_reorder_unit

Downstream neighbour of the incoming response buffer. Consumes whole R bursts, which arrive contiguously but out of request order, and stores each complete burst in one of NUM_SLOTS burst slots. Re-emits bursts on out_r strictly in AR issue order, as recorded through an allocation port fed by the AR path. Feeds the AXI master-side R channel.

## Interface
Parameters:
- ID_WIDTH, 4, RID width and order-queue entry width
- DATA_WIDTH, 64, R data width
- MAX_BEATS, 16, beats stored per slot
- NUM_SLOTS, 4, burst slots (≥2)
- ORDER_DEPTH, 16, outstanding AR IDs held in issue order (power of 2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_valid  in  1  AR issued; push alloc_id into order queue
- alloc_ready  out  1  order queue not full
- alloc_id  in  ID_WIDTH  ID of issued AR
- in_r  r_if.receiver  -  valid, ready, id, data, resp, last from the response buffer
- out_r  r_if.sender  -  valid, ready, id, data, resp, last toward the master
- err_unexpected_id  out  1  sticky; present only with R_REORDER_IDCHK_EN

## Operation
- Order queue: circular FIFO of ORDER_DEPTH IDs. Push on alloc_valid & alloc_ready. Pop on the out_r beat transfer with last=1. head_id is the oldest entry.
- Slot state per slot: busy, complete, id, nbeats (clog2(MAX_BEATS+1) bits), stamp (8-bit), payload and per-beat resp.
- Input write, first beat of a burst:
  - Allocate the lowest-index free slot.
  - Set busy, record id, stamp = seq_cnt, then seq_cnt++ (mod 256).
- Input write, subsequent beats: write to beat index nbeats, then nbeats++.
- Beats past MAX_BEATS: accepted, data discarded, nbeats saturates at MAX_BEATS.
- last beat: set complete.
- in_r.ready:
  - Mid-burst: always 1.
  - At first beat: 1 iff free_slots≥2, or (free_slots==1 & in_r.id==head_id & no busy slot holds head_id). The last free slot is reserved for the head ID (deadlock avoidance).
- Output FSM, IDLE:
  - If the order queue is non-empty and some complete slot has id==head_id, latch the oldest such slot and go to SEND.
  - Oldest = smallest stamp under modulo-256 compare; ≤127 outstanding stamps guaranteed.
- Output FSM, SEND:
  - Drive out_r.valid=1, id=slot id, data/resp = beat[idx], last = (idx==nbeats-1).
  - On each transfer, idx++.
  - On the last transfer: clear the slot's busy/complete, pop the order queue, go to IDLE.
- Slot freed in a cycle is not allocatable until the next cycle. free_slots is computed from registered state only.
- Same-cycle alloc push and order-queue pop on the last beat: both take effect; count unchanged.

## Timing
- Reset (async assert, sync release):
  - Order queue empty, all slots free, seq_cnt=0, FSM IDLE.
  - out_r.valid=0, id/data/resp/last=0.
  - alloc_ready=1, in_r.ready=1, err_unexpected_id=0.
- Reset mid-burst drops all stored and partial bursts; no output beat follows until new traffic arrives.
- Latency:
  - Last input beat accepted in cycle T → slot complete from T+1.
  - FSM selects in T+1 → out_r.valid first high in T+2, when head matches.
- Output throughput: one beat per cycle while out_r.ready=1. One idle cycle between bursts (SEND→IDLE→SEND).
- out_r holds valid/id/data/resp/last stable until ready.
- alloc_ready = ~full; a push while full is ignored.

## Configuration
- R_REORDER_IDCHK_EN defined:
  - On each accepted first beat whose id matches no order-queue entry, err_unexpected_id sets and stays 1 until reset.
  - The burst is still stored.
- Undefined: no ID-match logic, no err_unexpected_id port. Unexpected IDs are stored and never released.

## Test plan
- Allocs IDs 1,2; burst id2 (4 beats 0x20..0x23) arrives before id1 (2 beats 0x10,0x11) → out_r emits id1 0x10,0x11 (last on 0x11), then id2 0x20..0x23.
- In-order single 1-beat burst, out_r.ready=1 → last accepted T, out_r.valid at T+2, order queue empty afterwards.
- Allocs 5,5,7; bursts 5(a), 7, 5(b) → output 5(a), 5(b), 7; stamp order respected for same ID.
- NUM_SLOTS=4, head id 3 upstream, three non-head bursts fill slots → in_r.ready=0 for a 4th non-head first beat, =1 for id 3; no deadlock, all drain in order.
- out_r.ready toggled 1/0 per cycle during 8-beat burst → each beat held stable until accepted, no loss or duplication; reset asserted mid-SEND → out_r.valid=0 immediately.
- With R_REORDER_IDCHK_EN, burst id 9 never allocated → err_unexpected_id=1 next cycle and stays 1.
